// File: rtl/grid_sweep_pkg.sv
// Shared types and helpers for the grid sweep controller: FSM states, the
// removal threshold, the row-popcount width and a saturating 32-bit add.
package grid_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_SWEEP = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } sweep_state_e;

  localparam int unsigned REMOVE_THRESHOLD = 4;

  function automatic int unsigned row_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum_s[31:0];
    end
  endfunction

endpackage

// File: rtl/row_neighbor_eval.sv
// Combinational row evaluator: marks occupied cells of cur with fewer than
// REMOVE_THRESHOLD occupied neighbours across prev/cur/nxt.
module row_neighbor_eval
  import grid_sweep_pkg::*;
#(
  parameter  int WIDTH = 10,
  localparam int CNT_W = row_cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] mark,
  output logic [CNT_W-1:0] mark_cnt
);

  // Zero padding on both sides makes out-of-range columns read as empty.
  logic [WIDTH+1:0] prev_p_s;
  logic [WIDTH+1:0] cur_p_s;
  logic [WIDTH+1:0] nxt_p_s;

  assign prev_p_s = {1'b0, prev, 1'b0};
  assign cur_p_s  = {1'b0, cur, 1'b0};
  assign nxt_p_s  = {1'b0, nxt, 1'b0};

  // Per-column neighbour count, threshold compare and mark popcount.
  always_comb begin
    logic [3:0] nbr_s;
    mark     = '0;
    mark_cnt = '0;
    nbr_s    = 4'd0;
    for (int c = 0; c < WIDTH; c++) begin
      nbr_s = 4'(prev_p_s[c]) + 4'(prev_p_s[c+1]) + 4'(prev_p_s[c+2])
            + 4'(cur_p_s[c])                      + 4'(cur_p_s[c+2])
            + 4'(nxt_p_s[c])  + 4'(nxt_p_s[c+1])  + 4'(nxt_p_s[c+2]);
      mark[c]  = cur[c] && (nbr_s < 4'(REMOVE_THRESHOLD));
      mark_cnt = mark_cnt + CNT_W'(mark[c]);
    end
  end

endmodule

// File: rtl/grid_sweep_ctrl.sv
// Row-serial neighbour-removal controller: loads a grid, sweeps passes until
// one removes nothing. Define GRID_SWEEP_STATS_EN to keep the pass counter.
module grid_sweep_ctrl
  import grid_sweep_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             row_in_valid,
  output logic             row_in_ready,
  input  logic [WIDTH-1:0] row_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      total_removed,
  output logic [15:0]      pass_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = row_cnt_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  sweep_state_e     state_r;
  logic [IDX_W-1:0] idx_r;
  logic [WIDTH-1:0] rows_r [DEPTH];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] cur_r;
  logic [WIDTH-1:0] nxt_s;
  logic [WIDTH-1:0] mark_s;
  logic [CNT_W-1:0] mark_cnt_s;
  logic [31:0]      pass_removed_r;
  logic [31:0]      total_removed_r;
  logic             busy_r;
  logic             done_r;

  row_neighbor_eval #(.WIDTH(WIDTH)) u_eval (
    .prev     (prev_r),
    .cur      (cur_r),
    .nxt      (nxt_s),
    .mark     (mark_s),
    .mark_cnt (mark_cnt_s)
  );

  // Look-ahead row for the evaluator; the last row sees an empty row below it.
  always_comb begin
    nxt_s = '0;
    if (idx_r != LAST_IDX) begin
      nxt_s = rows_r[idx_r + 1'b1];
    end else begin
      nxt_s = '0;
    end
  end

  // Row storage: written by LOAD and by the survivors of each SWEEP row.
  always_ff @(posedge clk) begin
    if (state_r == ST_LOAD && row_in_valid) begin
      rows_r[idx_r] <= row_in;
    end else if (state_r == ST_SWEEP) begin
      rows_r[idx_r] <= cur_r & ~mark_s;
    end
  end

  // Main FSM with window registers, removal accumulators and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      idx_r           <= '0;
      prev_r          <= '0;
      cur_r           <= '0;
      pass_removed_r  <= 32'd0;
      total_removed_r <= 32'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r         <= ST_LOAD;
            idx_r           <= '0;
            total_removed_r <= 32'd0;
            busy_r          <= 1'b1;
            done_r          <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (row_in_valid) begin
            if (idx_r == LAST_IDX) begin
              state_r <= ST_PRIME;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end
        end
        ST_PRIME: begin
          prev_r         <= '0;
          cur_r          <= rows_r[0];
          idx_r          <= '0;
          pass_removed_r <= 32'd0;
          state_r        <= ST_SWEEP;
        end
        ST_SWEEP: begin
          // prev keeps the unmasked row so the whole pass sees the pre-pass grid.
          pass_removed_r <= pass_removed_r + 32'(mark_cnt_s);
          prev_r         <= cur_r;
          cur_r          <= nxt_s;
          if (idx_r == LAST_IDX) begin
            state_r <= ST_CHECK;
            idx_r   <= '0;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_CHECK: begin
          total_removed_r <= sat_add32(total_removed_r, pass_removed_r);
          if (pass_removed_r == 32'd0) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ST_PRIME;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign row_in_ready  = (state_r == ST_LOAD);
  assign busy          = busy_r;
  assign done          = done_r;
  assign total_removed = total_removed_r;

`ifdef GRID_SWEEP_STATS_EN
  localparam int unsigned PASS_LIMIT = WIDTH * DEPTH + 1;

  logic [15:0] pass_count_r;

  // Saturating pass counter, cleared on job start and stepped in CHECK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_count_r <= 16'd0;
    end else if ((state_r == ST_IDLE || state_r == ST_DONE) && start) begin
      pass_count_r <= 16'd0;
    end else if (state_r == ST_CHECK && pass_count_r != 16'hFFFF) begin
      pass_count_r <= pass_count_r + 16'd1;
    end
  end

  // Every pass but the last removes at least one cell, bounding the pass count.
  always_ff @(posedge clk) begin
    if (!rst && state_r == ST_CHECK) begin
      assert (32'(pass_count_r) <= PASS_LIMIT);
    end
  end

  assign pass_count = pass_count_r;
`else
  assign pass_count = 16'd0;
`endif

endmodule

// File: tb/tb_grid_sweep_ctrl.sv
// Directed and randomized bench for grid_sweep_ctrl on 3x3, 4x4 and 1x1 grids,
// checked against a whole-grid removal model.
module tb_grid_sweep_ctrl;

  typedef logic [3:0] grid_t [4];

  logic        clk;
  logic        rst;
  logic        start_s;
  logic        valid_s;
  logic [3:0]  row_s;
  int          sel;

  logic        rdy_a, busy_a, done_a;
  logic [31:0] tot_a;
  logic [15:0] pc_a;
  logic        rdy_b, busy_b, done_b;
  logic [31:0] tot_b;
  logic [15:0] pc_b;
  logic        rdy_c, busy_c, done_c;
  logic [31:0] tot_c;
  logic [15:0] pc_c;

  logic        rdy_o, busy_o, done_o;
  logic [31:0] tot_o;
  logic [15:0] pc_o;

  int n_vec;
  int n_err;

  grid_sweep_ctrl #(.WIDTH(3), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_s && sel == 0),
    .row_in_valid(valid_s && sel == 0), .row_in_ready(rdy_a), .row_in(row_s[2:0]),
    .busy(busy_a), .done(done_a), .total_removed(tot_a), .pass_count(pc_a)
  );

  grid_sweep_ctrl #(.WIDTH(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_s && sel == 1),
    .row_in_valid(valid_s && sel == 1), .row_in_ready(rdy_b), .row_in(row_s),
    .busy(busy_b), .done(done_b), .total_removed(tot_b), .pass_count(pc_b)
  );

  grid_sweep_ctrl #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s && sel == 2),
    .row_in_valid(valid_s && sel == 2), .row_in_ready(rdy_c), .row_in(row_s[0:0]),
    .busy(busy_c), .done(done_c), .total_removed(tot_c), .pass_count(pc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      0:       begin rdy_o = rdy_a; busy_o = busy_a; done_o = done_a; tot_o = tot_a; pc_o = pc_a; end
      1:       begin rdy_o = rdy_b; busy_o = busy_b; done_o = done_b; tot_o = tot_b; pc_o = pc_b; end
      default: begin rdy_o = rdy_c; busy_o = busy_c; done_o = done_c; tot_o = tot_c; pc_o = pc_c; end
    endcase
  end

  function automatic int pc_exp(input int p);
`ifdef GRID_SWEEP_STATS_EN
    return p;
`else
    return 0;
`endif
  endfunction

  // Whole-grid reference: repeat simultaneous removal passes until one removes nothing.
  function automatic void model(input grid_t gi, input int d, input int w,
                                output int tot, output int np);
    bit g [4][4];
    bit s [4][4];
    int rem, nb, rr, cc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = (r < d && c < w) ? gi[r][c] : 1'b0;
    tot = 0;
    np  = 0;
    do begin
      s   = g;
      rem = 0;
      for (int r = 0; r < d; r++) begin
        for (int c = 0; c < w; c++) begin
          if (s[r][c]) begin
            nb = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr;
                cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < d && cc >= 0 && cc < w && s[rr][cc])
                  nb++;
              end
            if (nb < 4) begin
              g[r][c] = 1'b0;
              rem++;
            end
          end
        end
      end
      np++;
      tot += rem;
    end while (rem != 0);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " ready"}, 64'(rdy_o), 64'd0);
    chk({tag, " busy"},  64'(busy_o), 64'd0);
    chk({tag, " done"},  64'(done_o), 64'd0);
    chk({tag, " total"}, 64'(tot_o), 64'd0);
    chk({tag, " passes"}, 64'(pc_o), 64'd0);
  endtask

  // Starts a job, feeds rows through the handshake and counts cycles until done.
  task automatic run_job(input int s, input grid_t g, input int d, input bit gap,
                         input int abort_n, output int cyc, output int load_cyc,
                         output bit timeout);
    int ri, j;
    bit rdy_pre, val_pre;
    sel = s; ri = 0; j = 0; timeout = 1'b0; load_cyc = 0;
    start_s = 1'b1;
    valid_s = gap;
    row_s   = 4'($urandom);
    @(posedge clk); #1;
    start_s = 1'b0;
    cyc = 1;
    while (!done_o && !timeout) begin
      if (abort_n != 0 && cyc == abort_n) begin
        rst = 1'b1;
        #1;
        break;
      end
      rdy_pre = rdy_o;
      start_s = 1'b0;
      if (rdy_o) begin
        valid_s = !gap || (j % 2 == 0);
        row_s   = (ri < d) ? g[ri] : 4'h0;
        j++;
      end else begin
        valid_s = gap;
        row_s   = 4'($urandom);
        start_s = gap && ri >= d && (cyc % 2 == 1);
      end
      val_pre = valid_s;
      @(posedge clk); #1;
      if (rdy_pre) begin
        load_cyc++;
        if (val_pre) ri++;
      end
      cyc++;
      if (cyc > 5000) timeout = 1'b1;
    end
    start_s = 1'b0;
    valid_s = 1'b0;
  endtask

  task automatic do_job(input string tag, input int s, input grid_t g, input int d,
                        input bit gap, input int exp_tot, input int exp_np);
    int cyc, lc, load_exp;
    bit to;
    load_exp = gap ? 2 * d - 1 : d;
    run_job(s, g, d, gap, 0, cyc, lc, to);
    chk({tag, " timeout"}, 64'(to), 64'd0);
    chk({tag, " latency"}, 64'(cyc), 64'(1 + load_exp + exp_np * (d + 2)));
    chk({tag, " load_cycles"}, 64'(lc), 64'(load_exp));
    chk({tag, " total"}, 64'(tot_o), 64'(exp_tot));
    chk({tag, " passes"}, 64'(pc_o), 64'(pc_exp(exp_np)));
    chk({tag, " busy"}, 64'(busy_o), 64'd0);
    chk({tag, " ready"}, 64'(rdy_o), 64'd0);
    @(posedge clk); #1;
    chk({tag, " done_held"}, 64'(done_o), 64'd1);
    chk({tag, " total_stable"}, 64'(tot_o), 64'(exp_tot));
  endtask

  initial begin
    grid_t g;
    int cyc, lc, mt, mp, d, w;
    bit to, gap;
    n_vec = 0; n_err = 0;
    rst = 1'b1; start_s = 1'b0; valid_s = 1'b0; row_s = 4'h0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk_reset_vals("reset");
    end
    rst = 1'b0;
    @(posedge clk); #1;

    g = '{4'h7, 4'h7, 4'h7, 4'h0};
    do_job("ones3", 0, g, 3, 1'b0, 9, 4);
    g = '{4'h7, 4'h5, 4'h7, 4'h0};
    do_job("ring3", 0, g, 3, 1'b0, 8, 3);
    g = '{4'h0, 4'h0, 4'h0, 4'h0};
    do_job("zero4", 1, g, 4, 1'b0, 0, 1);
    g = '{4'h1, 4'h0, 4'h0, 4'h0};
    do_job("one1", 2, g, 1, 1'b0, 1, 2);
    g = '{4'h7, 4'h7, 4'h7, 4'h0};
    do_job("ones3_gap", 0, g, 3, 1'b1, 9, 4);

    // Abort during the second sweep, then reload a different grid.
    run_job(0, g, 3, 1'b0, 11, cyc, lc, to);
    chk("abort reached", 64'(cyc), 64'd11);
    chk_reset_vals("abort");
    @(posedge clk); #1;
    chk_reset_vals("abort_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    g = '{4'h7, 4'h5, 4'h7, 4'h0};
    do_job("ring_after_abort", 0, g, 3, 1'b0, 8, 3);

    for (int k = 0; k < 16; k++) begin
      sel = (k % 3 == 0) ? 0 : 1;
      d   = (sel == 0) ? 3 : 4;
      w   = d;
      gap = 1'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) g[r] = 4'($urandom);
      model(g, d, w, mt, mp);
      do_job("random", sel, g, d, gap, mt, mp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/grid_sweep_ctrl.md
# grid_sweep_ctrl

Row-serial controller that sequences repeated neighbour-removal passes over a binary occupancy grid. It accepts the grid as a row stream, stores it internally, and runs passes until a pass removes nothing. Each pass evaluates every occupied cell against its 8 neighbours and removes cells with fewer than 4, with all removals in a pass decided on the pre-pass grid. It sits between the puzzle-input row loader and the result/report logic. It replaces the fully parallel whole-grid evaluation with one row-evaluator time-shared across rows.

## Interface
- WIDTH, 10, cells per row (≥1)
- DEPTH, 10, rows per grid (≥1)
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- start  in  1  begin a job; sampled only in IDLE or DONE
- row_in_valid  in  1  row_in carries a grid row
- row_in_ready  out  1  controller accepts a row this cycle
- row_in  in  WIDTH  row data; bit c = column c, 1 = occupied
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  job complete; held until next start
- total_removed  out  32  cells removed in the job; saturates at 32'hFFFF_FFFF
- pass_count  out  16  passes executed, including the final zero-removal pass; 0 when stats are compiled out

## Operation
- States: IDLE, LOAD, PRIME, SWEEP, CHECK, DONE.
- IDLE: on start → LOAD; total_removed, pass_count, and the row index are cleared.
- LOAD:
  - row_in_ready = 1.
  - Each valid&&ready cycle writes row_in to row[idx], then idx++.
  - After row DEPTH-1 is accepted → PRIME.
  - Gaps in row_in_valid stall LOAD with no other effect.
- PRIME (1 cycle): prev ← 0, cur ← row[0], idx ← 0, pass_removed ← 0.
- SWEEP: one row per cycle, for idx = 0..DEPTH-1.
  - nxt = row[idx+1], or 0 when idx = DEPTH-1.
  - The evaluator marks bit c of cur when cur[c]=1 and popcount of prev[c-1..c+1], cur[c±1], nxt[c-1..c+1] is < 4.
  - Out-of-range columns read 0.
  - row[idx] ← cur & ~mark; pass_removed += popcount(mark).
  - prev ← cur (unmasked, pre-pass value); cur ← nxt.
  - Because prev holds unmodified data, a pass is equivalent to simultaneous removal.
  - After idx = DEPTH-1 → CHECK.
- CHECK (1 cycle):
  - total_removed ← sat32(total_removed + pass_removed).
  - pass_count++ (saturating at 16'hFFFF).
  - If pass_removed = 0 → DONE, else → PRIME.
- DONE:
  - done = 1; row storage retains the final grid.
  - start → LOAD with done cleared and counters cleared, the same as from IDLE.
- start outside IDLE/DONE is ignored.
- row_in_valid outside LOAD is ignored, and nothing is consumed.
- Widths:
  - pass_removed is 32 bits.
  - The per-row mark popcount is clog2(WIDTH+1) bits, zero-extended.
  - The neighbour count is 4 bits.

## Timing
- Reset values: state IDLE, row_in_ready 0, busy 0, done 0, total_removed 0, pass_count 0. Row storage is not reset.
- Reset asserted mid-job aborts immediately to IDLE with all of the above values. The next start requires a full reload.
- Outputs are registered. row_in_ready is a decode of the registered state.
- LOAD takes ≥ DEPTH cycles (exactly DEPTH with continuous valid).
- Each pass takes exactly DEPTH+2 cycles (PRIME + DEPTH SWEEP + CHECK).
- done rises in the cycle after the CHECK that sees zero.
- total_removed and pass_count update only in CHECK, so they are stable while done = 1.
- Job latency from the start cycle = 1 (IDLE→LOAD) + load cycles + P·(DEPTH+2), where P = final pass_count.

## Configuration
- GRID_SWEEP_STATS_EN defined:
  - The pass_count register and increment logic are present.
  - CHECK also drives a SystemVerilog assertion that pass_count never exceeds WIDTH·DEPTH+1.
- GRID_SWEEP_STATS_EN undefined:
  - pass_count is tied to 16'd0 and no counter register exists.
  - All other behaviour and timing are identical.

## Structure
- Shared package grid_sweep_pkg contains:
  - the state enum;
  - REMOVE_THRESHOLD = 4;
  - a function for the row-popcount width;
  - the saturating 32-bit add function.
- Sub-module row_neighbor_eval (combinational, parameter WIDTH):
  - inputs prev, cur, nxt;
  - outputs mark[WIDTH-1:0] and mark_cnt.
- The controller owns the FSM, row storage, window registers and counters.

## Test plan
- 3×3 all ones, continuous valid → passes remove 4, 4, 1, 0; total_removed = 9, pass_count = 4, done 3+1+4·5 = 24 cycles after start.
- 3×3 ring (all ones except centre) → passes remove 4, 4, 0; total_removed = 8, pass_count = 3.
- 4×4 all zeros → total_removed = 0, pass_count = 1, done after 1+4+6 cycles.
- 1×1 single occupied cell → total_removed = 1, pass_count = 2.
- 3×3 all ones with row_in_valid high every other cycle → same results as the first scenario, with LOAD lasting ≥ 5 cycles. Rows offered outside LOAD are not consumed.
- Assert rst during the second SWEEP of the first scenario → all outputs at reset values next cycle. Restart with the ring grid → total_removed = 8.
